rock_level_ctrl: RTL and testbench
==================================

// Module: rock_level_ctrl
// PURPOSE
//  Parametrised successor of the rocking controller. Turns stress events from the stress
//  detector into amplitude/frequency drive levels for the Output module. Adds what the
//  fixed 3-bit controller lacks:
//   - generic level width
//   - on-chip slow-tick prescaler
//   - timed hold/evaluate escalation
//   - selectable escalation order
//   - gradual decay when calm
//   - error latch with software clear
//  Sits between the stress detector (stressContinu one-tick, stressLaag) and Output.
// PARAMETERS
//  LVL_W       3      width of amp/freq levels; max level LMAX = 2**LVL_W-1
//  CLK_DIV     50000  clk cycles per slow tick (>=2)
//  HOLD_TICKS  8      slow ticks spent at a level before evaluation (>=1)
//  MAX_TRIES   4      escalation requests at amp=freq=LMAX before error (>=1)
//  FREQ_FIRST  1      1: raise freq to LMAX before amp; 0: raise amp first
// PORTS
//  clk         in   1      system clock
//  extReset    in   1      asynchronous reset, active-low
//  stressEvt   in   1      one-cycle pulse: stress still present
//  stressLow   in   1      level: stress low / baby calm
//  clrErr      in   1      one-cycle pulse: leave ERROR
//  amp         out  LVL_W  amplitude level to Output
//  freq        out  LVL_W  frequency level to Output
//  error       out  1      stuck at max drive without effect
//  busy        out  1      high in any state except IDLE
//  lvlChg      out  1      one-cycle pulse the cycle after amp or freq changes
// BEHAVIOUR
//  Reset (extReset=0, async): all outputs 0; state IDLE; prescaler, holdCnt, tries and
//   pend are all 0. Reset asserted mid-operation aborts immediately.
//  Prescaler: free-running 0..CLK_DIV-1. tick=1 for the single cycle where count=CLK_DIV-1.
//  All state changes are registered; outputs are taken straight from registers.
//  IDLE:
//   - stressEvt -> amp=1, freq=1, holdCnt=0, pend=0 -> HOLD.
//  HOLD:
//   - stressEvt sets pend.
//   - On tick: holdCnt++. At holdCnt=HOLD_TICKS-1 with tick -> EVAL.
//  EVAL (exactly 1 cycle):
//   - pend=1, levels not both LMAX: raise one level by +1 per FREQ_FIRST order; tries=0.
//   - pend=1, both at LMAX: tries++; if tries reaches MAX_TRIES -> ERROR.
//   - pend=0 and stressLow=1 -> DECAY.
//   - Otherwise -> HOLD.
//   - Every exit to HOLD clears holdCnt and pend.
//   - A stressEvt arriving in the EVAL cycle counts toward this evaluation.
//  DECAY:
//   - On each tick, lower one level by 1, reverse of escalation order (FREQ_FIRST=1: amp
//     first).
//   - Both levels at 0 -> IDLE.
//   - stressEvt -> HOLD at the current levels (holdCnt=0, pend=1); any level already 0
//     is forced to 1.
//  ERROR:
//   - amp=freq=0, error=1; stressEvt ignored.
//   - clrErr -> IDLE with tries=0 and error=0.
//  Arithmetic: levels saturate at 0 and LMAX and never wrap. tries saturates at
//   MAX_TRIES.
//  Simultaneous events:
//   - stressEvt beats stressLow.
//   - clrErr outside ERROR is ignored.
//   - A tick coinciding with stressEvt in DECAY does not decrement.
//  lvlChg: one-cycle pulse the cycle after the amp/freq registers change; never raised
//   by reset.
// TESTING (LVL_W=2, CLK_DIV=4, HOLD_TICKS=2, MAX_TRIES=2, FREQ_FIRST=1)
//  1 Reset: extReset=0 mid-HOLD at amp=2 -> amp=freq=0, error=0, busy=0 in the same cycle.
//  2 Escalate: stressEvt once per hold window -> (a,f) goes
//    (1,1)->(1,2)->(1,3)->(2,3)->(3,3); lvlChg pulses once per step.
//  3 Error: keep stressEvt at (3,3) for 2 further windows -> error=1, amp=freq=0;
//    stressEvt ignored; clrErr -> IDLE with error=0.
//  4 Decay: at (2,3), stressLow=1 and no stressEvt -> amp 2->1->0, then freq 3->2->1->0,
//    one step per 4 cycles, then IDLE with busy=0.
//  5 Re-trigger: stressEvt in DECAY at (0,2) -> HOLD at (1,2); stressEvt+stressLow in the
//    same EVAL cycle -> escalate to (1,3).
//  6 FREQ_FIRST=0: repeat test 2 -> (1,1)->(2,1)->(3,1)->(3,2)->(3,3).

Source files
------------

// File: rtl/rock_level_ctrl.sv
// Rocking level controller: turns stress events into amplitude/frequency drive levels,
// with timed hold/evaluate escalation, decay when calm and an error latch.
module rock_level_ctrl #(
    parameter int LVL_W      = 3,
    parameter int CLK_DIV    = 50000,
    parameter int HOLD_TICKS = 8,
    parameter int MAX_TRIES  = 4,
    parameter int FREQ_FIRST = 1
) (
    input  logic             clk,
    input  logic             extReset,
    input  logic             stressEvt,
    input  logic             stressLow,
    input  logic             clrErr,
    output logic [LVL_W-1:0] amp,
    output logic [LVL_W-1:0] freq,
    output logic             error,
    output logic             busy,
    output logic             lvlChg
);

    localparam int PW = $clog2(CLK_DIV);
    localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam int TW = $clog2(MAX_TRIES + 1);
    localparam logic [LVL_W-1:0] LMAX  = '1;
    localparam logic [LVL_W-1:0] LONE  = LVL_W'(1);
    localparam logic [PW-1:0]    PLAST = PW'(CLK_DIV - 1);
    localparam logic [HW-1:0]    HLAST = HW'(HOLD_TICKS - 1);
    localparam logic [TW-1:0]    TMAX  = TW'(MAX_TRIES);

    typedef enum logic [2:0] {S_IDLE, S_HOLD, S_EVAL, S_DECAY, S_ERROR} state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    presc_q;
    logic [HW-1:0]    hold_q, hold_d;
    logic [TW-1:0]    tries_q, tries_d, tries_inc;
    logic [LVL_W-1:0] amp_q, amp_d, freq_q, freq_d;
    logic             pend_q, pend_d;
    logic             err_q, busy_q, chg_q;
    logic             tick, at_max;

    assign tick      = (presc_q == PLAST);
    assign at_max    = (amp_q == LMAX) && (freq_q == LMAX);
    assign tries_inc = (tries_q == TMAX) ? TMAX : tries_q + 1'b1;

    always_ff @(posedge clk or negedge extReset) begin
        if (!extReset) presc_q <= '0;
        else           presc_q <= tick ? '0 : presc_q + 1'b1;
    end

    always_comb begin
        state_d = state_q;
        amp_d   = amp_q;
        freq_d  = freq_q;
        hold_d  = hold_q;
        pend_d  = pend_q;
        tries_d = tries_q;
        case (state_q)
            S_IDLE: begin
                if (stressEvt) begin
                    amp_d   = LONE;
                    freq_d  = LONE;
                    hold_d  = '0;
                    pend_d  = 1'b0;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (stressEvt) pend_d = 1'b1;
                if (tick) begin
                    if (hold_q == HLAST) state_d = S_EVAL;
                    else                 hold_d  = hold_q + 1'b1;
                end
            end
            S_EVAL: begin
                // An event landing in this very cycle still counts toward the evaluation.
                hold_d  = '0;
                pend_d  = 1'b0;
                state_d = S_HOLD;
                if (pend_q || stressEvt) begin
                    if (!at_max) begin
                        tries_d = '0;
                        if (FREQ_FIRST != 0) begin
                            if (freq_q != LMAX) freq_d = freq_q + 1'b1;
                            else                amp_d  = amp_q + 1'b1;
                        end else begin
                            if (amp_q != LMAX)  amp_d  = amp_q + 1'b1;
                            else                freq_d = freq_q + 1'b1;
                        end
                    end else begin
                        tries_d = tries_inc;
                        if (tries_inc == TMAX) begin
                            state_d = S_ERROR;
                            amp_d   = '0;
                            freq_d  = '0;
                        end
                    end
                end else if (stressLow) begin
                    state_d = S_DECAY;
                end
            end
            S_DECAY: begin
                if (stressEvt) begin
                    if (amp_q == '0)  amp_d  = LONE;
                    if (freq_q == '0) freq_d = LONE;
                    hold_d  = '0;
                    pend_d  = 1'b1;
                    state_d = S_HOLD;
                end else if (amp_q == '0 && freq_q == '0) begin
                    state_d = S_IDLE;
                end else if (tick) begin
                    // Unwind in the opposite order to escalation.
                    if (FREQ_FIRST != 0) begin
                        if (amp_q != '0) amp_d  = amp_q - 1'b1;
                        else             freq_d = freq_q - 1'b1;
                    end else begin
                        if (freq_q != '0) freq_d = freq_q - 1'b1;
                        else              amp_d  = amp_q - 1'b1;
                    end
                end
            end
            S_ERROR: begin
                if (clrErr) begin
                    state_d = S_IDLE;
                    tries_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge extReset) begin
        if (!extReset) begin
            state_q <= S_IDLE;
            amp_q   <= '0;
            freq_q  <= '0;
            hold_q  <= '0;
            pend_q  <= 1'b0;
            tries_q <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            chg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            amp_q   <= amp_d;
            freq_q  <= freq_d;
            hold_q  <= hold_d;
            pend_q  <= pend_d;
            tries_q <= tries_d;
            err_q   <= (state_d == S_ERROR);
            busy_q  <= (state_d != S_IDLE);
            chg_q   <= (amp_d != amp_q) || (freq_d != freq_q);
        end
    end

    assign amp    = amp_q;
    assign freq   = freq_q;
    assign error  = err_q;
    assign busy   = busy_q;
    assign lvlChg = chg_q;

endmodule

// File: tb/tb_rock_level_ctrl.sv
// Bench for rock_level_ctrl: two instances (escalate freq-first and amp-first) on shared
// inputs, compared every cycle against a behavioural model plus fixed expected sequences.
module tb_rock_level_ctrl;

    localparam int CLK_DIV = 4;
    localparam int HT      = 2;
    localparam int MT      = 2;
    localparam int LM      = 3;
    localparam int ST_IDLE = 0, ST_HOLD = 1, ST_EVAL = 2, ST_DECAY = 3, ST_ERR = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic evt = 1'b0, low = 1'b0, clr = 1'b0;
    logic [1:0] amp0, freq0, amp1, freq1;
    logic err0, busy0, chg0, err1, busy1, chg1;
    wire  [6:0] obs [2];

    int ntests = 0, nfail = 0;
    int mst[2], ma[2], mf[2], mht[2], mtries[2], mpc;
    bit mpend[2], mchg[2];

    always #5 clk = ~clk;

    rock_level_ctrl #(.LVL_W(2), .CLK_DIV(CLK_DIV), .HOLD_TICKS(HT), .MAX_TRIES(MT), .FREQ_FIRST(1)) dut0 (
        .clk(clk), .extReset(rst_n), .stressEvt(evt), .stressLow(low), .clrErr(clr),
        .amp(amp0), .freq(freq0), .error(err0), .busy(busy0), .lvlChg(chg0));
    rock_level_ctrl #(.LVL_W(2), .CLK_DIV(CLK_DIV), .HOLD_TICKS(HT), .MAX_TRIES(MT), .FREQ_FIRST(0)) dut1 (
        .clk(clk), .extReset(rst_n), .stressEvt(evt), .stressLow(low), .clrErr(clr),
        .amp(amp1), .freq(freq1), .error(err1), .busy(busy1), .lvlChg(chg1));

    assign obs[0] = {amp0, freq0, err0, busy0, chg0};
    assign obs[1] = {amp1, freq1, err1, busy1, chg1};

    function automatic logic [6:0] exp_vec(int m);
        return {2'(ma[m]), 2'(mf[m]), mst[m] == ST_ERR, mst[m] != ST_IDLE, mchg[m]};
    endfunction

    task automatic model_reset();
        mpc = 0;
        for (int m = 0; m < 2; m++) begin
            mst[m] = ST_IDLE; ma[m] = 0; mf[m] = 0; mht[m] = 0; mtries[m] = 0;
            mpend[m] = 0; mchg[m] = 0;
        end
    endtask

    task automatic to_hold(int m);
        mst[m] = ST_HOLD; mht[m] = 0; mpend[m] = 0;
    endtask

    // m=0 escalates frequency first, m=1 amplitude first.
    task automatic model_step(int m, bit tk);
        int pa, pf;
        bit ff;
        ff = (m == 0);
        pa = ma[m]; pf = mf[m];
        case (mst[m])
            ST_IDLE: if (evt) begin ma[m] = 1; mf[m] = 1; to_hold(m); end
            ST_HOLD: begin
                if (evt) mpend[m] = 1;
                if (tk) begin
                    if (mht[m] == HT - 1) mst[m] = ST_EVAL;
                    else mht[m]++;
                end
            end
            ST_EVAL: begin
                if ((mpend[m] || evt) && !(ma[m] == LM && mf[m] == LM)) begin
                    if (ff) begin if (mf[m] < LM) mf[m]++; else ma[m]++; end
                    else    begin if (ma[m] < LM) ma[m]++; else mf[m]++; end
                    mtries[m] = 0;
                    to_hold(m);
                end else if (mpend[m] || evt) begin
                    mtries[m] = (mtries[m] + 1 > MT) ? MT : mtries[m] + 1;
                    if (mtries[m] >= MT) begin mst[m] = ST_ERR; ma[m] = 0; mf[m] = 0; end
                    else to_hold(m);
                end else if (low) mst[m] = ST_DECAY;
                else to_hold(m);
            end
            ST_DECAY: begin
                if (evt) begin
                    if (ma[m] == 0) ma[m] = 1;
                    if (mf[m] == 0) mf[m] = 1;
                    to_hold(m);
                    mpend[m] = 1;
                end else if (ma[m] == 0 && mf[m] == 0) mst[m] = ST_IDLE;
                else if (tk) begin
                    if (ff) begin if (ma[m] > 0) ma[m]--; else mf[m]--; end
                    else    begin if (mf[m] > 0) mf[m]--; else ma[m]--; end
                end
            end
            default: if (clr) begin mst[m] = ST_IDLE; mtries[m] = 0; end
        endcase
        mchg[m] = (pa != ma[m]) || (pf != mf[m]);
    endtask

    task automatic step();
        bit tk;
        @(posedge clk);
        tk = (mpc % CLK_DIV) == CLK_DIV - 1;
        mpc++;
        model_step(0, tk);
        model_step(1, tk);
        #1;
    endtask

    task automatic do_reset();
        evt = 0; low = 0; clr = 0;
        @(negedge clk);
        rst_n = 0;
        model_reset();
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_reset();
        int n;
        do_reset();
        rst_n = 0;
        #1;
        ntests++;
        if (obs[0] !== 7'b0 || obs[1] !== 7'b0) begin
            nfail++; $display("FAIL reset_idle got %b/%b want 0", obs[0], obs[1]);
        end
        @(negedge clk);
        rst_n = 1;
        n = 0;
        while (!(ma[0] == 2 && mst[0] == ST_HOLD) && n < 300) begin
            evt = (mst[0] == ST_IDLE) || (mst[0] == ST_HOLD && !mpend[0]);
            step();
            for (int m = 0; m < 2; m++) begin
                ntests++;
                if (obs[m] !== exp_vec(m)) begin
                    nfail++; $display("FAIL reset_run m%0d t=%0t got %b want %b", m, $time, obs[m], exp_vec(m));
                end
            end
            n++;
        end
        ntests++;
        if (n >= 300) begin nfail++; $display("FAIL reset_reach timeout got %0d want <300", n); end
        evt = 0;
        #2;
        rst_n = 0;
        model_reset();
        #1;
        ntests++;
        if (obs[0] !== 7'b0 || obs[1] !== 7'b0) begin
            nfail++; $display("FAIL reset_async got %b/%b want 0", obs[0], obs[1]);
        end
        @(negedge clk);
        rst_n = 1;
        repeat (6) begin
            step();
            for (int m = 0; m < 2; m++) begin
                ntests++;
                if (obs[m] !== exp_vec(m)) begin
                    nfail++; $display("FAIL reset_after m%0d got %b want %b", m, obs[m], exp_vec(m));
                end
            end
        end
    endtask

    task automatic test_escalate();
        int q0[$], q1[$], p0, p1, n, last0, last1;
        int e0[5] = '{5, 6, 7, 11, 15};
        int e1[5] = '{5, 9, 13, 14, 15};
        do_reset();
        p0 = 0; p1 = 0; n = 0; last0 = 0; last1 = 0;
        while (!(ma[0] == LM && mf[0] == LM) && n < 300) begin
            evt = (mst[0] == ST_IDLE) || (mst[0] == ST_HOLD && !mpend[0]);
            step();
            for (int m = 0; m < 2; m++) begin
                ntests++;
                if (obs[m] !== exp_vec(m)) begin
                    nfail++; $display("FAIL escalate m%0d t=%0t got %b want %b", m, $time, obs[m], exp_vec(m));
                end
            end
            if (int'({amp0, freq0}) != last0) begin last0 = int'({amp0, freq0}); q0.push_back(last0); end
            if (int'({amp1, freq1}) != last1) begin last1 = int'({amp1, freq1}); q1.push_back(last1); end
            p0 += int'(chg0);
            p1 += int'(chg1);
            n++;
        end
        evt = 0;
        ntests++;
        if (q0.size() != 5 || q1.size() != 5) begin
            nfail++; $display("FAIL escalate_len got %0d/%0d want 5", q0.size(), q1.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                ntests++;
                if (q0[i] != e0[i] || q1[i] != e1[i]) begin
                    nfail++; $display("FAIL escalate_seq step %0d got %0d/%0d want %0d/%0d", i, q0[i], q1[i], e0[i], e1[i]);
                end
            end
        end
        ntests++;
        if (p0 != 5 || p1 != 5) begin nfail++; $display("FAIL escalate_pulses got %0d/%0d want 5", p0, p1); end
    endtask

    task automatic test_error();
        int n = 0;
        while (mst[0] != ST_ERR && n < 100) begin
            evt = (mst[0] == ST_HOLD && !mpend[0]);
            step();
            for (int m = 0; m < 2; m++) begin
                ntests++;
                if (obs[m] !== exp_vec(m)) begin
                    nfail++; $display("FAIL error_run m%0d t=%0t got %b want %b", m, $time, obs[m], exp_vec(m));
                end
            end
            n++;
        end
        ntests++;
        if (err0 !== 1'b1 || amp0 !== 2'd0 || freq0 !== 2'd0 || err1 !== 1'b1) begin
            nfail++; $display("FAIL error_latch got err=%b a=%0d f=%0d want err=1 a=0 f=0", err0, amp0, freq0);
        end
        evt = 1;
        repeat (12) begin
            step();
            for (int m = 0; m < 2; m++) begin
                ntests++;
                if (obs[m] !== exp_vec(m)) begin
                    nfail++; $display("FAIL error_hold m%0d got %b want %b", m, obs[m], exp_vec(m));
                end
            end
        end
        evt = 0; clr = 1;
        step();
        clr = 0;
        ntests++;
        if (obs[0] !== 7'b0 || obs[1] !== 7'b0) begin
            nfail++; $display("FAIL error_clear got %b/%b want 0", obs[0], obs[1]);
        end
    endtask

    task automatic test_decay();
        int q[$], tq[$], n = 0, last, cyc = 0;
        int e[6] = '{11, 7, 3, 2, 1, 0};
        do_reset();
        while (!(ma[0] == 2 && mf[0] == LM) && n < 300) begin
            evt = (mst[0] == ST_IDLE) || (mst[0] == ST_HOLD && !mpend[0]);
            step();
            n++;
        end
        evt = 0; low = 1;
        last = int'({amp0, freq0});
        q.push_back(last);
        n = 0;
        while (mst[0] != ST_IDLE && n < 200) begin
            step();
            cyc++;
            for (int m = 0; m < 2; m++) begin
                ntests++;
                if (obs[m] !== exp_vec(m)) begin
                    nfail++; $display("FAIL decay m%0d t=%0t got %b want %b", m, $time, obs[m], exp_vec(m));
                end
            end
            if (int'({amp0, freq0}) != last) begin
                last = int'({amp0, freq0}); q.push_back(last); tq.push_back(cyc);
            end
            n++;
        end
        ntests++;
        if (q.size() != 6) begin
            nfail++; $display("FAIL decay_len got %0d want 6", q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                ntests++;
                if (q[i] != e[i]) begin nfail++; $display("FAIL decay_seq step %0d got %0d want %0d", i, q[i], e[i]); end
            end
            for (int i = 1; i < 5; i++) begin
                ntests++;
                if (tq[i] - tq[i-1] != CLK_DIV) begin
                    nfail++; $display("FAIL decay_rate step %0d got %0d cycles want %0d", i, tq[i] - tq[i-1], CLK_DIV);
                end
            end
        end
        ntests++;
        if (busy0 !== 1'b0) begin nfail++; $display("FAIL decay_idle busy got %b want 0", busy0); end
        low = 0;
    endtask

    task automatic test_retrigger();
        int n = 0;
        do_reset();
        while (!(ma[0] == 2 && mf[0] == LM) && n < 300) begin
            evt = (mst[0] == ST_IDLE) || (mst[0] == ST_HOLD && !mpend[0]);
            step();
            n++;
        end
        evt = 0; low = 1; n = 0;
        while (!(mst[0] == ST_DECAY && ma[0] == 0 && mf[0] == 2) && n < 200) begin
            step();
            n++;
        end
        evt = 1;
        step();
        evt = 0;
        ntests++;
        if (amp0 !== 2'd1 || freq0 !== 2'd2 || busy0 !== 1'b1) begin
            nfail++; $display("FAIL retrig_hold got a=%0d f=%0d busy=%b want a=1 f=2 busy=1", amp0, freq0, busy0);
        end
        n = 0;
        while (mst[0] != ST_EVAL && n < 50) begin
            step();
            for (int m = 0; m < 2; m++) begin
                ntests++;
                if (obs[m] !== exp_vec(m)) begin
                    nfail++; $display("FAIL retrig m%0d got %b want %b", m, obs[m], exp_vec(m));
                end
            end
            n++;
        end
        evt = 1;
        step();
        evt = 0; low = 0;
        ntests++;
        if (amp0 !== 2'd1 || freq0 !== 2'd3 || chg0 !== 1'b1) begin
            nfail++; $display("FAIL retrig_eval got a=%0d f=%0d chg=%b want a=1 f=3 chg=1", amp0, freq0, chg0);
        end
    endtask

    task automatic test_random();
        do_reset();
        repeat (1500) begin
            evt = ($urandom_range(7) == 0);
            low = $urandom_range(1);
            clr = ($urandom_range(15) == 0);
            step();
            for (int m = 0; m < 2; m++) begin
                ntests++;
                if (obs[m] !== exp_vec(m)) begin
                    nfail++; $display("FAIL random m%0d t=%0t got %b want %b", m, $time, obs[m], exp_vec(m));
                end
            end
        end
        evt = 0; low = 0; clr = 0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_escalate();
        test_error();
        test_decay();
        test_retrigger();
        test_random();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
